// File: rtl/confused_pkg.sv
// Shared definitions for the divide/modulo controller: data width, request
// op encodings, controller state encoding and the divide-by-zero result rule.
package confused_pkg;

   localparam int DATA_W = 16;

   typedef enum logic {
      OP_DIV = 1'b0,
      OP_MOD = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   // A zero divisor never reaches the divider: a divide saturates to all
   // ones, while a modulo hands the dividend back unchanged.
   function automatic logic [DATA_W-1:0] dbz_result(op_e op, logic [DATA_W-1:0] a);
      return (op == OP_MOD) ? a : '1;
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Core-side request/response bundle of the divide controller.
// master = the core issuing requests, slave = the controller.
interface div_ctrl_if;
   import confused_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_op;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic              resp_dbz;
   logic              resp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_dbz, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_data, resp_dbz, resp_err
   );

endinterface

// File: rtl/div_cache.sv
// Single-entry result cache: remembers the last divider operands together
// with both quotient and remainder, so either op on the same operands hits.
module div_cache
   import confused_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_a,
   input  logic [DATA_W-1:0] fill_b,
   input  logic [DATA_W-1:0] fill_quot,
   input  logic [DATA_W-1:0] fill_rem,
   input  logic [DATA_W-1:0] lookup_a,
   input  logic [DATA_W-1:0] lookup_b,
   output logic              hit,
   output logic [DATA_W-1:0] hit_quot,
   output logic [DATA_W-1:0] hit_rem
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] quot_q, quot_d;
   logic [DATA_W-1:0] rem_q, rem_d;

   // Entry update: a flush always beats a fill arriving on the same edge.
   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (fill) begin
         valid_d = 1'b1;
         a_d     = fill_a;
         b_d     = fill_b;
         quot_d  = fill_quot;
         rem_d   = fill_rem;
      end
   end

   // Entry storage; reset only needs to drop the valid bit but clears all.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   // Hit compare against the live request operands.
   always_comb begin
      hit      = valid_q && (lookup_a == a_q) && (lookup_b == b_q);
      hit_quot = quot_q;
      hit_rem  = rem_q;
   end

endmodule

// File: rtl/div_ctrl.sv
// Divide/modulo controller: accepts core requests, answers zero-divisor and
// cached requests directly, otherwise launches the external divider and
// waits for it with a timeout.
module div_ctrl
   import confused_pkg::*;
#(
   parameter int TIMEOUT = 24
) (
   input  logic              clk,
   input  logic              reset,
   div_ctrl_if.slave         bus,
   output logic              stall,
   output logic              div_start,
   output logic [DATA_W-1:0] div_dividend,
   output logic [DATA_W-1:0] div_divisor,
   input  logic              div_done,
   input  logic [DATA_W-1:0] div_quot,
   input  logic [DATA_W-1:0] div_rem,
   input  logic              flush
);

   localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              flush_seen_q, flush_seen_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              resp_dbz_q, resp_dbz_d;
   logic              resp_err_q, resp_err_d;
   logic              fill;
   logic              hit;
   logic [DATA_W-1:0] hit_quot;
   logic [DATA_W-1:0] hit_rem;

   div_cache u_cache (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .fill      (fill),
      .fill_a    (a_q),
      .fill_b    (b_q),
      .fill_quot (div_quot),
      .fill_rem  (div_rem),
      .lookup_a  (bus.req_a),
      .lookup_b  (bus.req_b),
      .hit       (hit),
      .hit_quot  (hit_quot),
      .hit_rem   (hit_rem)
   );

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_DIV;
         a_q          <= '0;
         b_q          <= '0;
         cnt_q        <= '0;
         flush_seen_q <= 1'b0;
         resp_data_q  <= '0;
         resp_dbz_q   <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         cnt_q        <= cnt_d;
         flush_seen_q <= flush_seen_d;
         resp_data_q  <= resp_data_d;
         resp_dbz_q   <= resp_dbz_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Next state: zero divisor and cache hits skip the divider entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               state_d = ((bus.req_b == '0) || hit) ? ST_RESP : ST_LAUNCH;
            end
         end
         ST_LAUNCH: state_d = ST_WAIT;
         ST_WAIT: begin
            if (div_done || (cnt_q == TO_LAST)) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, wait counter, flush tracking and response
   // fields, which are only written on the way into RESP so they hold there.
   always_comb begin
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      cnt_d        = cnt_q;
      flush_seen_d = flush_seen_q;
      resp_data_d  = resp_data_q;
      resp_dbz_d   = resp_dbz_q;
      resp_err_d   = resp_err_q;
      fill         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               op_d         = op_e'(bus.req_op);
               a_d          = bus.req_a;
               b_d          = bus.req_b;
               cnt_d        = '0;
               flush_seen_d = 1'b0;
               resp_dbz_d   = 1'b0;
               resp_err_d   = 1'b0;
               if (bus.req_b == '0) begin
                  resp_data_d = dbz_result(op_e'(bus.req_op), bus.req_a);
                  resp_dbz_d  = 1'b1;
               end else if (hit) begin
                  resp_data_d = (op_e'(bus.req_op) == OP_MOD) ? hit_rem : hit_quot;
               end
            end
         end
         ST_LAUNCH: begin
            cnt_d = '0;
            if (flush) begin
               flush_seen_d = 1'b1;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 5'd1;
            if (flush) begin
               flush_seen_d = 1'b1;
            end
            if (div_done) begin
               resp_data_d = (op_q == OP_MOD) ? div_rem : div_quot;
               resp_dbz_d  = 1'b0;
               resp_err_d  = 1'b0;
               fill        = !flush && !flush_seen_q;
            end else if (cnt_q == TO_LAST) begin
               resp_data_d = '0;
               resp_dbz_d  = 1'b0;
               resp_err_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Outputs decoded from state plus the registered operands and response.
   always_comb begin
      bus.req_ready  = (state_q == ST_IDLE);
      bus.resp_valid = (state_q == ST_RESP);
      bus.resp_data  = resp_data_q;
      bus.resp_dbz   = resp_dbz_q;
      bus.resp_err   = resp_err_q;
      div_start      = (state_q == ST_LAUNCH);
      div_dividend   = a_q;
      div_divisor    = b_q;
      stall          = (bus.req_valid && (state_q != ST_IDLE)) ||
                       (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed scenarios followed by random
// requests, all compared against a transaction-level reference model.
module tb_div_ctrl;
   localparam int TIMEOUT = 24;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        div_start;
   logic [15:0] div_dividend;
   logic [15:0] div_divisor;
   logic        div_done;
   logic [15:0] div_quot;
   logic [15:0] div_rem;
   logic        flush;

   div_ctrl_if bus ();

   div_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .stall        (stall),
      .div_start    (div_start),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_done     (div_done),
      .div_quot     (div_quot),
      .div_rem      (div_rem),
      .flush        (flush)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divider model: div_done rises div_delay cycles after the div_start
   // cycle; a delay of 0 means it never answers.
   int          div_delay;
   int          m_cnt;
   logic [15:0] m_a, m_b;
   initial begin
      m_cnt = 0;
      m_a   = '0;
      m_b   = '0;
   end
   always @(posedge clk) begin
      if (div_start) begin
         m_cnt <= div_delay;
         m_a   <= div_dividend;
         m_b   <= div_divisor;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
      end
   end
   assign div_done = (m_cnt == 1);
   assign div_quot = (m_b != 0) ? m_a / m_b : 16'h0;
   assign div_rem  = (m_b != 0) ? m_a % m_b : 16'h0;

   // Reference cache: one remembered operand pair.
   bit          ref_valid;
   logic [15:0] ref_a, ref_b;

   int n_checks;
   int n_fail;

   // Safety net so the run always ends.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full request/response transaction with expectations taken from the
   // reference model. hold = cycles resp_ready stays low once resp_valid is
   // seen; flush_at = cycle after acceptance at which flush is pulsed.
   task automatic apply_stimulus(input string tag, input logic op, input logic [15:0] a,
                                 input logic [15:0] b, input int delay, input int hold,
                                 input int flush_at);
      bit          is_dbz, is_hit, is_miss, is_to;
      int          exp_lat, lat, starts;
      logic [15:0] exp_data;
      is_dbz  = (b == 0);
      is_hit  = !is_dbz && ref_valid && (ref_a == a) && (ref_b == b);
      is_miss = !is_dbz && !is_hit;
      is_to   = is_miss && (delay == 0);
      if (is_dbz || is_hit) exp_lat = 1;
      else if (is_to)       exp_lat = 2 + TIMEOUT;
      else                  exp_lat = 2 + delay;
      if (is_dbz)      exp_data = op ? a : 16'hFFFF;
      else if (is_to)  exp_data = 16'h0;
      else             exp_data = op ? (a % b) : (a / b);
      if (flush_at > 0) ref_valid = 1'b0;
      if (is_miss && !is_to && flush_at == 0) begin
         ref_valid = 1'b1;
         ref_a     = a;
         ref_b     = b;
      end

      div_delay     = delay;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      #1;
      check_output({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      lat    = 1;
      starts = 0;
      while (!bus.resp_valid && lat < 100) begin
         starts += int'(div_start);
         if (flush_at > 0 && lat == flush_at) flush = 1'b1;
         tick();
         flush = 1'b0;
         lat++;
      end
      check_output({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check_output({tag, " data"}, 32'(bus.resp_data), 32'(exp_data));
      check_output({tag, " dbz"}, 32'(bus.resp_dbz), 32'(is_dbz));
      check_output({tag, " err"}, 32'(bus.resp_err), 32'(is_to));
      check_output({tag, " div_start"}, 32'(starts), is_miss ? 32'd1 : 32'd0);

      if (hold > 0) begin
         bus.req_valid = 1'b1;
         bus.req_a     = ~a;
         bus.req_b     = ~b;
         for (int i = 0; i < hold; i++) begin
            tick();
            check_output({tag, " hold valid"}, 32'(bus.resp_valid), 32'd1);
            check_output({tag, " hold data"}, 32'(bus.resp_data), 32'(exp_data));
            check_output({tag, " hold ready"}, 32'(bus.req_ready), 32'd0);
            check_output({tag, " hold stall"}, 32'(stall), 32'd1);
         end
      end
      bus.resp_ready = 1'b1;
      bus.req_valid  = 1'b0;
      tick();
      bus.resp_ready = 1'b0;
      check_output({tag, " done valid"}, 32'(bus.resp_valid), 32'd0);
      check_output({tag, " back idle"}, 32'(bus.req_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
      check_output({tag, " stall"}, 32'(stall), 32'd0);
      check_output({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
      check_output({tag, " resp_dbz"}, 32'(bus.resp_dbz), 32'd0);
      check_output({tag, " resp_err"}, 32'(bus.resp_err), 32'd0);
      check_output({tag, " div_start"}, 32'(div_start), 32'd0);
      check_output({tag, " resp_data"}, 32'(bus.resp_data), 32'd0);
      check_output({tag, " dividend"}, 32'(div_dividend), 32'd0);
      check_output({tag, " divisor"}, 32'(div_divisor), 32'd0);
   endtask

   // Directed scenarios, then random traffic.
   initial begin
      logic        r_op;
      logic [15:0] r_a, r_b;
      n_checks       = 0;
      n_fail         = 0;
      ref_valid      = 1'b0;
      ref_a          = '0;
      ref_b          = '0;
      div_delay      = 0;
      flush          = 1'b0;
      reset          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_op     = 1'b0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b0;

      repeat (3) tick();
      check_reset_outputs("reset");
      reset = 1'b1;
      tick();

      $display("[TB] miss then hit");
      apply_stimulus("div100_7", 1'b0, 16'd100, 16'd7, 16, 0, 0);
      apply_stimulus("mod100_7", 1'b1, 16'd100, 16'd7, 16, 0, 0);

      $display("[TB] divide by zero");
      apply_stimulus("div5_0", 1'b0, 16'd5, 16'd0, 16, 0, 0);
      apply_stimulus("mod5_0", 1'b1, 16'd5, 16'd0, 16, 0, 0);

      $display("[TB] response backpressure");
      apply_stimulus("hold1000_33", 1'b0, 16'd1000, 16'd33, 3, 3, 0);

      $display("[TB] divider timeout");
      apply_stimulus("timeout", 1'b1, 16'd50, 16'd9, 0, 0, 0);
      apply_stimulus("after_to", 1'b1, 16'd50, 16'd9, 4, 0, 0);

      $display("[TB] flush during wait");
      apply_stimulus("flush9_2", 1'b0, 16'd9, 16'd2, 10, 0, 5);
      apply_stimulus("repeat9_2", 1'b0, 16'd9, 16'd2, 10, 0, 0);

      $display("[TB] reset mid-wait");
      div_delay     = 16;
      bus.req_valid = 1'b1;
      bus.req_op    = 1'b0;
      bus.req_a     = 16'd8;
      bus.req_b     = 16'd3;
      tick();
      bus.req_valid = 1'b0;
      repeat (6) tick();
      check_output("midwait stall", 32'(stall), 32'd1);
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      tick();
      reset     = 1'b1;
      ref_valid = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         check_output("late done resp", 32'(bus.resp_valid), 32'd0);
         check_output("late done idle", 32'(bus.req_ready), 32'd1);
      end
      apply_stimulus("post_reset9_2", 1'b0, 16'd9, 16'd2, 6, 0, 0);

      $display("[TB] random requests");
      r_a = 16'd9;
      r_b = 16'd2;
      for (int i = 0; i < 10; i++) begin
         r_op = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) != 0) begin
            r_a = 16'($urandom);
            r_b = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
         end
         apply_stimulus("random", r_op, r_a, r_b,
                        ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20)),
                        int'($urandom_range(0, 2)), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 24, is the maximum number of cycles spent in WAIT before the operation is aborted.
REQ-002 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 Port req_valid  input  1  core presents a divide/modulo request.
REQ-005 Port req_ready  output  1  controller accepts the request this cycle.
REQ-006 Port req_op  input  1  request type: 0 = DIV (quotient), 1 = MOD (remainder).
REQ-007 Ports req_a / req_b  input  16 each  dividend / divisor.
REQ-008 Port resp_valid  output  1  result is available.
REQ-009 Port resp_ready  input  1  core consumes the result.
REQ-010 Port resp_data  output  16  quotient or remainder.
REQ-011 Port resp_dbz  output  1  divisor was zero.
REQ-012 Port resp_err  output  1  divider timed out.
REQ-013 Port stall  output  1  pipeline stall: high when req_valid is high and req_ready is low, or when the FSM is in LAUNCH or WAIT.
REQ-014 Port div_start  output  1  one-cycle launch pulse to the divider.
REQ-015 Ports div_dividend / div_divisor  output  16 each  registered operands to the divider.
REQ-016 Port div_done  input  1  divider result valid this cycle.
REQ-017 Ports div_quot / div_rem  input  16 each  divider results, sampled only when div_done is high.
REQ-018 Port flush  input  1  invalidates the result cache.

Function
REQ-019 The FSM SHALL have states IDLE, LAUNCH, WAIT and RESP; req_ready is high only in IDLE.
REQ-020 On acceptance, the controller SHALL register req_op, req_a and req_b, then transition as follows:
- divisor zero -> RESP;
- cache hit (cache valid, req_a and req_b both equal the cached operands) -> RESP;
- otherwise -> LAUNCH.
REQ-021 Zero-divisor result: resp_data = 16'hFFFF for DIV and req_a for MOD; resp_dbz = 1; divider not started; cache unchanged; latency 1 cycle.
REQ-022 Cache-hit result: resp_data = cached quotient (DIV) or cached remainder (MOD); latency 1 cycle.
REQ-023 LAUNCH SHALL assert div_start for exactly one cycle with the operands stable, then go to WAIT.
REQ-024 In WAIT, a 5-bit counter SHALL increment every cycle. Exit conditions:
- div_done -> capture both results, fill the cache (unless suppressed by REQ-027), go to RESP;
- counter reaches TIMEOUT-1 without div_done -> go to RESP with resp_err = 1, resp_data = 0, no cache fill.
REQ-025 div_done outside WAIT SHALL be ignored.
REQ-026 In RESP, resp_valid and all response fields SHALL hold stable until resp_ready is high, then the FSM returns to IDLE. A response takes at least 1 cycle; there is no back-to-back accept in the RESP cycle.
REQ-027 flush SHALL clear cache_valid on the next edge. A flush asserted during LAUNCH or WAIT suppresses the fill for that operation. Flush and fill in the same cycle: flush wins.
REQ-028 Miss latency from acceptance to resp_valid = 2 + (divider cycles to div_done).

Reset
REQ-029 While reset = 0, the controller SHALL force:
- state to IDLE and cache_valid to 0;
- req_ready to 1 and stall to 0;
- resp_valid, resp_dbz, resp_err, div_start to 0;
- resp_data, div_dividend, div_divisor to 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no response; a later div_done is ignored.

Structure
REQ-031 The state enum, the DIV/MOD op encodings and the data width of 16 SHALL live in the shared package confused_pkg.
REQ-032 The cache (operands, quotient, remainder, valid, hit compare) SHALL be the sub-module div_cache; the FSM, counter and response registers stay in div_ctrl.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- DIV 100/7 (miss, divider model done after 16 cycles) -> div_start pulses once; resp_data = 14 with 18-cycle latency.
- Next, MOD 100/7 -> cache hit, no div_start, resp_data = 2 one cycle after acceptance.
- DIV 5/0 -> resp_data = 16'hFFFF, resp_dbz = 1; MOD 5/0 -> resp_data = 5; no div_start in either case.
- Result with resp_ready held low 3 cycles -> resp_valid and resp_data stable throughout; req_ready low and stall high whenever req_valid is high.
- Divider never asserts div_done, TIMEOUT = 24 -> resp_err = 1, resp_data = 0; a repeat of the same request misses the cache.
- flush pulsed during WAIT of 9/2, then reset pulled low mid-WAIT of 8/3 -> 9/2 still returns 4 but a repeat misses; after reset the controller is in IDLE and a late div_done produces no response.
